// File: rtl/cordic_pkg.sv
// cordic_pkg: widths, constants, FSM states and the atan table shared by the CORDIC engines
package cordic_pkg;
  localparam int IN_W = 8;
  localparam int INT_W = 16;
  localparam int Z_W = 14;
  localparam int ANG_W = 9;
  localparam int ITERS_MAX = 11;
  localparam int PI_Q10 = 3217;
  localparam int GAIN_Q10 = 622;
  localparam logic [11:0] ATAN_TAB [ITERS_MAX] = '{
    12'd804, 12'd475, 12'd251, 12'd127, 12'd64, 12'd32,
    12'd16, 12'd8, 12'd4, 12'd2, 12'd1
  };
  typedef enum logic [2:0] {IDLE, PRE, ITER, SCALE, DONE} state_t;
endpackage

// File: rtl/cordic_vectoring_if.sv
// cordic_vectoring_if: Cartesian input and polar result valid/ready handshakes
interface cordic_vectoring_if;
  import cordic_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [IN_W-1:0] x_in, y_in;
  logic signed [ANG_W-1:0] angle_out;
  logic [IN_W-1:0] mag_out;
  modport master (output in_valid, x_in, y_in, out_ready, input in_ready, out_valid, angle_out, mag_out);
  modport slave (input in_valid, x_in, y_in, out_ready, output in_ready, out_valid, angle_out, mag_out);
endinterface

// File: rtl/cordic_vectoring_lut.sv
// cordic_vectoring_lut: atan(2^-i) in Q2.10, zero beyond the last table entry
module cordic_vectoring_lut
  import cordic_pkg::*;
(
  input  logic [4:0]  idx,
  output logic [11:0] atan
);
  always_comb atan = (idx < 5'(ITERS_MAX)) ? ATAN_TAB[idx[3:0]] : '0;
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring CORDIC, (x, y) -> (atan2(y, x), gain-compensated magnitude)
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int ITERS = ITERS_MAX
) (
  input logic clk,
  input logic rst_n,
  cordic_vectoring_if.slave bus
);
  state_t state, state_nx;
  logic signed [INT_W-1:0] x, y, x_nx, y_nx, xs, ys;
  logic signed [Z_W-1:0] z, z_nx, za, z_rnd;
  logic [3:0] i, i_nx;
  logic zero_flag, zero_nx;
  logic signed [ANG_W-1:0] angle, angle_nx;
  logic [IN_W-1:0] mag, mag_nx;
  logic [11:0] atan;
  logic signed [31:0] prod, mag_q;

  cordic_vectoring_lut u_lut (.idx({1'b0, i}), .atan(atan));

  assign xs = x >>> i;
  assign ys = y >>> i;
  assign za = {2'b00, atan};
  assign prod = 32'(x) * GAIN_Q10 + (1 << 13);
  assign mag_q = prod >>> 14;
  assign z_rnd = (z + Z_W'(8)) >>> 4;

  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.angle_out = angle;
  assign bus.mag_out = mag;

  always_comb begin
    state_nx = state;
    x_nx = x;
    y_nx = y;
    z_nx = z;
    i_nx = i;
    zero_nx = zero_flag;
    angle_nx = angle;
    mag_nx = mag;
    case (state)
      IDLE: if (bus.in_valid) begin
        x_nx = {{4{bus.x_in[IN_W-1]}}, bus.x_in, 4'b0};
        y_nx = {{4{bus.y_in[IN_W-1]}}, bus.y_in, 4'b0};
        z_nx = '0;
        i_nx = '0;
        state_nx = PRE;
      end
      PRE: begin
        // left half-plane: rotate by pi so the iterations only see |angle| <= pi/2
        x_nx = x[INT_W-1] ? -x : x;
        y_nx = x[INT_W-1] ? -y : y;
        z_nx = !x[INT_W-1] ? '0 : y[INT_W-1] ? -Z_W'(PI_Q10) : Z_W'(PI_Q10);
        zero_nx = x == '0 && y == '0;
        state_nx = ITER;
      end
      ITER: begin
        x_nx = y[INT_W-1] ? x - ys : x + ys;
        y_nx = y[INT_W-1] ? y + xs : y - xs;
        z_nx = y[INT_W-1] ? z - za : z + za;
        i_nx = i + 4'd1;
        state_nx = (i == 4'(ITERS - 1)) ? SCALE : ITER;
      end
      SCALE: begin
        mag_nx = zero_flag ? '0 : mag_q > 255 ? 8'd255 : mag_q < 0 ? '0 : mag_q[IN_W-1:0];
        angle_nx = zero_flag ? '0 : ANG_W'(z_rnd);
        state_nx = DONE;
      end
      DONE: state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      zero_flag <= 1'b0;
      angle <= '0;
      mag <= '0;
    end else begin
      state <= state_nx;
      x <= x_nx;
      y <= y_nx;
      z <= z_nx;
      i <= i_nx;
      zero_flag <= zero_nx;
      angle <= angle_nx;
      mag <= mag_nx;
    end
endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative CORDIC in vectoring mode. It is the inverse of the sine/cosine rotation engine: it accepts a Cartesian point (x, y) and returns its polar form, the angle atan2(y, x) and the gain-compensated magnitude. It sits beside the rotation engine in the DSP datapath and uses the same Q.10 internal arithmetic and the same arctangent table. Both input and output use valid/ready handshakes, and the block processes one vector at a time.

## Interface
- ITERS, 11: number of micro-rotations, i = 0..ITERS-1. Maximum is 11.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  x_in/y_in are valid.
- in_ready  output  1  block can accept a vector. High only in IDLE.
- x_in  input  8  signed Q2.6.
- y_in  input  8  signed Q2.6.
- out_valid  output  1  angle_out/mag_out are valid.
- out_ready  input  1  consumer accepts the result.
- angle_out  output  9  signed Q3.6 radians, range [-π, π].
- mag_out  output  8  unsigned Q2.6, √(x²+y²).

## Operation
- Internal registers:
  - x and y: 16-bit signed Q5.10. Inputs are sign-extended and shifted left 4.
  - z: 14-bit signed Q3.10.
- States: IDLE → PRE → ITER → SCALE → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch the inputs, clear z and i, and go to PRE.
- PRE (quadrant fold):
  - If x<0: x←-x, y←-y. z←+PI_Q10 (3217) when the original y≥0, otherwise -PI_Q10.
  - Otherwise pass through.
  - Record zero_flag = (x_in==0 && y_in==0).
  - Go to ITER.
- ITER, one micro-rotation per cycle, with a = atan(2^-i) from the table:
  - If y≥0: x←x+(y>>>i), y←y-(x>>>i), z←z+a.
  - If y<0: x←x-(y>>>i), y←y+(x>>>i), z←z-a.
  - All right-hand sides use pre-update values. Shifts are arithmetic.
  - After i=ITERS-1, go to SCALE.
- SCALE:
  - mag = sat255((x·GAIN_Q10 + 2^13) >>> 14), with GAIN_Q10=622 (≈0.6073).
  - angle = (z + 8) >>> 4, truncated to 9 bits.
  - If zero_flag, force both outputs to 0.
  - Go to DONE.
- DONE:
  - out_valid=1. Outputs are held stable while out_ready=0.
  - On out_ready, go to IDLE. in_ready rises the following cycle; no accept happens in the same cycle as the output handshake.
- Table values (Q2.10): 804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1.

## Timing
- Reset (async, rst=0): state=IDLE, x=y=z=i=0, zero_flag=0, out_valid=0, angle_out=0, mag_out=0. in_ready=1 once reset is released.
- Latency: input accepted at edge k. PRE at edge k+1. ITER at edges k+2..k+1+ITERS. SCALE at edge k+2+ITERS. out_valid is high after edge k+2+ITERS, which is edge k+13 for ITERS=11.
- Minimum interval between accepts: ITERS+4 cycles (15 for ITERS=11), given out_ready is held high.
- in_valid while busy is ignored: no accept, and the input is not queued.
- Reset asserted mid-ITER or mid-DONE aborts immediately. No out_valid is produced for the aborted vector.
- angle_out and mag_out change only on the SCALE→DONE edge and during reset.

## Structure
- cordic_pkg holds:
  - widths: IN_W=8, INT_W=16, Z_W=14, ANG_W=9;
  - constants: ITERS_MAX=11, PI_Q10=3217, GAIN_Q10=622;
  - the state enum;
  - the shared atan table constants, so the rotation and vectoring engines use identical values.
- Sub-module: the existing lut (5-bit index in, 12-bit Q2.10 atan out), instanced once and indexed by i.

## Test plan
- x=0x40 (1.0), y=0 → angle_out=0 (±1 LSB), mag_out=0x40 (±1). out_valid exactly 13 cycles after the accept edge.
- x=0x40, y=0x40 → angle_out=50 (π/4, ±1), mag_out=90 or 91.
- x=0xC0 (-1.0), y=0 → angle_out=201 (π, ±1), mag_out=64 (±1). Also x=0, y=0xC0 → angle_out=-100 (9-bit 0x19C, ±1), mag_out=64 (±1).
- x=0, y=0 → angle_out=0, mag_out=0 exactly. x=0x80, y=0x80 → mag_out=181 (±1), angle_out=-151 (±1), no overflow.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid pulsed. Outputs remain stable and in_ready stays 0. On release, IDLE is reached one cycle later and then the next vector is accepted.
- Pull rst low at ITER i=5, then release and send a new vector. No stale out_valid appears, and the new result is correct with nominal latency.
